demux_1_8_seq: RTL and testbench

//  Registered 1-to-8 demultiplexer/distributor: the receive-side inverse of the 8:1 mux path.

---
 rtl/demux_1_8_seq_pkg.sv | 22 ++
 rtl/demux_1_8_seq_if.sv | 28 ++
 rtl/demux_1_8_seq_lane_reg.sv | 19 +
 rtl/demux_1_8_seq.sv | 104 ++++++++++
 tb/tb_demux_1_8_seq.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/demux_1_8_seq_pkg.sv
// Shared definitions for the 1-to-8 registered demultiplexer.
// Provides the lane count, select width, FSM state type and a one-hot
// lane decode helper used by the top level.
package demux_pkg;

    localparam int N_LANE = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } demux_state_t;

    // One-hot decode of a lane index.
    function automatic logic [N_LANE-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
        logic [N_LANE-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_1_8_seq_if.sv
// Bus bundle for demux_1_8_seq.
// Upstream side: mode, sel, din, din_valid, din_ready.
// Downstream side: dout, lane_wr, frame_valid, frame_ack.
// master: the environment driving words in and consuming frames.
// slave : the demultiplexer itself.
interface demux_1_8_seq_if import demux_pkg::*; #(parameter int DATA_W = 1);

    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [DATA_W-1:0]        din;
    logic                     din_valid;
    logic                     din_ready;
    logic [N_LANE*DATA_W-1:0] dout;
    logic [N_LANE-1:0]        lane_wr;
    logic                     frame_valid;
    logic                     frame_ack;

    modport master (
        output mode, sel, din, din_valid, frame_ack,
        input  din_ready, dout, lane_wr, frame_valid
    );

    modport slave (
        input  mode, sel, din, din_valid, frame_ack,
        output din_ready, dout, lane_wr, frame_valid
    );

endinterface

// File: rtl/demux_1_8_seq_lane_reg.sv
// Single output lane register of the demultiplexer.
// Ports: clk, rst (sync, active-high), en (write enable), d (data in),
// q (registered lane value).
module demux_lane_reg #(parameter int DATA_W = 1) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/demux_1_8_seq.sv
// Registered 1-to-8 demultiplexer / frame assembler.
// Ports: clk, rst (sync, active-high), bus (slave modport of demux_1_8_seq_if).
// Addressed mode (mode=0) writes each accepted word to lane sel.
// Auto mode (mode=1) fills lanes 0..7 in order, then holds the frame
// with frame_valid until frame_ack.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting words; in auto mode lane_cnt selects the next lane
// HOLD  | auto frame complete; input stalled, dout frozen, awaiting ack
module demux_1_8_seq import demux_pkg::*; #(parameter int DATA_W = 1) (
    input  logic            clk,
    input  logic            rst,
    demux_1_8_seq_if.slave  bus
);

    demux_state_t             state_q, state_d;
    logic [SEL_W-1:0]         cnt_q, cnt_d;
    logic [N_LANE-1:0]        lane_wr_q;
    logic [N_LANE-1:0]        lane_we;
    logic [N_LANE*DATA_W-1:0] dout_w;
    logic                     ready;
    logic                     xfer;
    logic                     frame_valid;
    logic [SEL_W-1:0]         target;

    // State and counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            lane_wr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_wr_q <= lane_we;
        end
    end

    // Next-state logic. Addressed mode overrides the FSM every cycle, so a
    // partial auto frame is abandoned (lanes keep their contents).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.mode) begin
            state_d = FILL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (xfer) begin
                        cnt_d = cnt_q + 3'd1;   // wraps 7 -> 0 on frame completion
                        if (cnt_q == SEL_W'(N_LANE - 1))
                            state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.frame_ack) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output / handshake logic
    always_comb begin
        ready       = 1'b0;
        frame_valid = 1'b0;
        xfer        = 1'b0;
        target      = '0;
        lane_we     = '0;
        ready       = !bus.mode || (state_q == FILL);
        frame_valid = (state_q == HOLD);
        xfer        = bus.din_valid && ready;
        target      = bus.mode ? cnt_q : bus.sel;
        if (xfer)
            lane_we = lane_onehot(target);
    end

    genvar k;
    generate
        for (k = 0; k < N_LANE; k++) begin : g_lane
            demux_lane_reg #(.DATA_W(DATA_W)) u_lane (
                .clk (clk),
                .rst (rst),
                .en  (lane_we[k]),
                .d   (bus.din),
                .q   (dout_w[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign bus.din_ready   = ready;
    assign bus.frame_valid = frame_valid;
    assign bus.lane_wr     = lane_wr_q;
    assign bus.dout        = dout_w;

endmodule

// File: tb/tb_demux_1_8_seq.sv
module tb_demux_1_8_seq;
    import demux_pkg::*;

    typedef struct packed {
        logic [7:0] dout;
        logic [7:0] lane_wr;
        logic       fv;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_1_8_seq_if #(.DATA_W(1)) bus ();
    demux_1_8_seq #(.DATA_W(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic       m_hold;
    logic [2:0] m_cnt;
    logic [7:0] m_dout;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the reference outcome is queued when driven
    // and compared once the DUT has clocked.
    task automatic step(input logic r, input logic m, input logic v, input logic d,
                        input logic [2:0] s, input logic a);
        exp_t       e;
        logic       rdy;
        logic [7:0] lw;
        rst           = r;
        bus.mode      = m;
        bus.din_valid = v;
        bus.din       = d;
        bus.sel       = s;
        bus.frame_ack = a;
        #1;
        rdy = !m || !m_hold;
        lw  = 8'h00;
        if (!r) chk("din_ready", {7'b0, bus.din_ready}, {7'b0, rdy});
        if (r) begin
            m_hold = 1'b0; m_cnt = 3'd0; m_dout = 8'h00;
        end else if (!m) begin
            m_hold = 1'b0; m_cnt = 3'd0;
            if (v) begin m_dout[s] = d; lw[s] = 1'b1; end
        end else if (!m_hold) begin
            if (v) begin
                m_dout[m_cnt] = d;
                lw[m_cnt]     = 1'b1;
                if (m_cnt == 3'd7) m_hold = 1'b1;
                m_cnt = m_cnt + 3'd1;
            end
        end else if (a) begin
            m_hold = 1'b0; m_cnt = 3'd0;
        end
        e.dout = m_dout; e.lane_wr = lw; e.fv = m_hold;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("dout", bus.dout, e.dout);
        chk("lane_wr", bus.lane_wr, e.lane_wr);
        chk("frame_valid", {7'b0, bus.frame_valid}, {7'b0, e.fv});
    endtask

    logic [7:0] pat;

    initial begin
        m_hold = 1'b0; m_cnt = 3'd0; m_dout = 8'h00;

        // 1: reset
        step(1, 0, 0, 0, 3'd0, 0);
        step(1, 0, 0, 0, 3'd0, 0);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_lane_wr", bus.lane_wr, 8'h00);
        chk("rst_fv", {7'b0, bus.frame_valid}, 8'h00);
        step(0, 0, 0, 0, 3'd0, 0);

        // 2: addressed write to lane 5
        step(0, 0, 1, 1, 3'd5, 0);
        chk("t2_lane_wr", bus.lane_wr, 8'h20);
        chk("t2_dout", bus.dout, 8'h20);
        step(0, 0, 0, 0, 3'd0, 1);   // ack outside HOLD is ignored
        for (int i = 0; i < 8; i++)
            step(0, 0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 3'($urandom_range(7, 0)), 0);

        // 3: auto frame
        pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) step(0, 1, 1, pat[i], 3'd0, 0);
        chk("t3_fv", {7'b0, bus.frame_valid}, 8'h01);
        chk("t3_dout", bus.dout, 8'h4D);
        chk("t3_ready", {7'b0, bus.din_ready}, 8'h00);

        // 4: stall in HOLD, then ack with din_valid high
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1'(i), 3'd3, 0);
        chk("t4_dout", bus.dout, 8'h4D);
        chk("t4_lane_wr", bus.lane_wr, 8'h00);
        step(0, 1, 1, 1, 3'd0, 1);
        chk("t4_fv", {7'b0, bus.frame_valid}, 8'h00);
        chk("t4_ready", {7'b0, bus.din_ready}, 8'h01);
        step(0, 1, 1, 0, 3'd0, 0);
        chk("t4_lane0", bus.lane_wr, 8'h01);

        // 5: abandon partial frame by switching to addressed mode
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 3'd0, 0);
        step(0, 0, 0, 0, 3'd0, 0);
        chk("t5_fv", {7'b0, bus.frame_valid}, 8'h00);
        step(0, 1, 1, 1, 3'd6, 0);
        chk("t5_restart", bus.lane_wr, 8'h01);

        // 6: reset mid-frame, then a full frame
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 3'd0, 0);
        step(1, 1, 1, 1, 3'd0, 0);
        chk("t6_dout", bus.dout, 8'h00);
        chk("t6_lane_wr", bus.lane_wr, 8'h00);
        pat = 8'hB2;
        for (int i = 0; i < 8; i++) step(0, 1, 1, pat[i], 3'd0, 0);
        chk("t6_fv", {7'b0, bus.frame_valid}, 8'h01);
        chk("t6_frame", bus.dout, 8'hB2);
        step(0, 1, 0, 0, 3'd0, 1);
        chk("t6_ack", {7'b0, bus.frame_valid}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
